// File: rtl/cumulative_histogram_pctl_if.sv
// ----------------------------------------------------------------------------
// cumulative_histogram_pctl_if
//   Bundles the control handshake, percentile targets, histogram RAM read
//   port, cumulative RAM write port and result outputs of the cumulative
//   histogram engine. Clock and reset stay plain ports on the block.
//
//   slave  : the engine (drives oAddrInHist, the write port, results).
//   master : the surrounding system (drives start/ack, targets, RAM data).
//
//   iStart / iAck           start pulse and done acknowledge
//   iPctlLo / iPctlHi       low/high percentile target sample counts
//   iQInHist, oAddrInHist   histogram RAM read data / address
//   oDataOutCumH, oAddrOutCumH, oWE   cumulative RAM write port
//   oThreshLo/Hi, oLoHit/oHiHit       percentile bins and hit flags
//   oMaxValue, oMaxBin, oTotal, oOverflow   statistics
//   oBusy, oDone            status
// ----------------------------------------------------------------------------
interface cumulative_histogram_pctl_if #(
    parameter int BIN_BITS    = 8,
    parameter int COUNT_WIDTH = 20
);
    logic                   iStart;
    logic                   iAck;
    logic [COUNT_WIDTH-1:0] iPctlLo;
    logic [COUNT_WIDTH-1:0] iPctlHi;
    logic [COUNT_WIDTH-1:0] iQInHist;
    logic [BIN_BITS-1:0]    oAddrInHist;
    logic [COUNT_WIDTH-1:0] oDataOutCumH;
    logic [BIN_BITS-1:0]    oAddrOutCumH;
    logic                   oWE;
    logic [BIN_BITS-1:0]    oThreshLo;
    logic [BIN_BITS-1:0]    oThreshHi;
    logic                   oLoHit;
    logic                   oHiHit;
    logic [COUNT_WIDTH-1:0] oMaxValue;
    logic [BIN_BITS-1:0]    oMaxBin;
    logic [COUNT_WIDTH-1:0] oTotal;
    logic                   oOverflow;
    logic                   oBusy;
    logic                   oDone;

    modport slave (
        input  iStart, iAck, iPctlLo, iPctlHi, iQInHist,
        output oAddrInHist, oDataOutCumH, oAddrOutCumH, oWE,
               oThreshLo, oThreshHi, oLoHit, oHiHit,
               oMaxValue, oMaxBin, oTotal, oOverflow, oBusy, oDone
    );

    modport master (
        output iStart, iAck, iPctlLo, iPctlHi, iQInHist,
        input  oAddrInHist, oDataOutCumH, oAddrOutCumH, oWE,
               oThreshLo, oThreshHi, oLoHit, oHiHit,
               oMaxValue, oMaxBin, oTotal, oOverflow, oBusy, oDone
    );
endinterface

// File: rtl/cumulative_histogram_pctl.sv
// ----------------------------------------------------------------------------
// cumulative_histogram_pctl
//   Scans a 2^BIN_BITS-bin histogram RAM, writes the saturating running sum
//   into a cumulative-histogram RAM, and reports two programmable percentile
//   bins, the peak bin and its count, and the total sample count.
//
//   Ports:
//     iClk  clock
//     iRst  asynchronous active-high reset
//     bus   cumulative_histogram_pctl_if.slave (handshake, RAM ports, results)
//
//   READ_LATENCY is the histogram RAM address-to-data delay (1..3 cycles).
//   A valid shift register of that depth follows each issued address, so
//   the write side never needs to know the address that produced the data.
// ----------------------------------------------------------------------------
module cumulative_histogram_pctl #(
    parameter int BIN_BITS     = 8,
    parameter int COUNT_WIDTH  = 20,
    parameter int READ_LATENCY = 1
) (
    input  logic iClk,
    input  logic iRst,
    cumulative_histogram_pctl_if.slave bus
);
    localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t                  state, state_nxt;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [BIN_BITS-1:0]     bin_idx;     // bin whose data arrives next
    logic [COUNT_WIDTH-1:0]  acc;
    logic [COUNT_WIDTH-1:0]  pctl_lo;
    logic [COUNT_WIDTH-1:0]  pctl_hi;
    logic [COUNT_WIDTH:0]    sum_wide;
    logic [COUNT_WIDTH-1:0]  cum;
    logic                    data_vld;
    logic                    last_wr_seen;

    assign data_vld = vld_pipe[READ_LATENCY-1];

    // One extra bit catches the carry; saturate instead of wrapping.
    assign sum_wide = {1'b0, acc} + {1'b0, bus.iQInHist};
    assign cum      = sum_wide[COUNT_WIDTH] ? '1 : sum_wide[COUNT_WIDTH-1:0];

    // The last bin's write is on the port this cycle.
    assign last_wr_seen = bus.oWE && (bus.oAddrOutCumH == LAST_BIN);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        bus.oBusy = 1'b0;
        bus.oDone = 1'b0;
        // A start restarts from any state and wins over a same-cycle ack.
        if (bus.iStart) begin
            state_nxt = SCAN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                SCAN:    if (bus.oAddrInHist == LAST_BIN) state_nxt = FLUSH;
                FLUSH:   if (last_wr_seen) state_nxt = DONE;
                DONE:    if (bus.iAck) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        bus.oBusy = (state == SCAN) || (state == FLUSH);
        bus.oDone = (state == DONE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        // NOTE: all state here is updated with non-blocking assignments so
        // every register samples pre-edge values, independent of order.
        if (iRst) begin
            pctl_lo          <= '0;
            pctl_hi          <= '0;
            acc              <= '0;
            vld_pipe         <= '0;
            bin_idx          <= '0;
            bus.oAddrInHist  <= '0;
            bus.oDataOutCumH <= '0;
            bus.oAddrOutCumH <= '0;
            bus.oWE          <= 1'b0;
            bus.oThreshLo    <= '0;
            bus.oThreshHi    <= '0;
            bus.oLoHit       <= 1'b0;
            bus.oHiHit       <= 1'b0;
            bus.oMaxValue    <= '0;
            bus.oMaxBin      <= '0;
            bus.oTotal       <= '0;
            bus.oOverflow    <= 1'b0;
        end else if (bus.iStart) begin
            // Flushing vld_pipe drops any reads still in flight from an
            // interrupted scan. oTotal keeps the previous result until the
            // new scan completes.
            pctl_lo         <= bus.iPctlLo;
            pctl_hi         <= bus.iPctlHi;
            acc             <= '0;
            vld_pipe        <= '0;
            bin_idx         <= '0;
            bus.oAddrInHist <= '0;
            bus.oWE         <= 1'b0;
            bus.oThreshLo   <= '0;
            bus.oThreshHi   <= '0;
            bus.oLoHit      <= 1'b0;
            bus.oHiHit      <= 1'b0;
            bus.oMaxValue   <= '0;
            bus.oMaxBin     <= '0;
            bus.oOverflow   <= 1'b0;
        end else begin
            if (state == SCAN && bus.oAddrInHist != LAST_BIN)
                bus.oAddrInHist <= bus.oAddrInHist + 1'b1;

            vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(state == SCAN);
            bus.oWE  <= data_vld;

            if (data_vld) begin
                acc              <= cum;
                bus.oAddrOutCumH <= bin_idx;
                bus.oDataOutCumH <= cum;
                bin_idx          <= bin_idx + 1'b1;
                if (sum_wide[COUNT_WIDTH]) bus.oOverflow <= 1'b1;

                // First crossing only; an unreached target parks on the
                // last bin when that bin is written.
                if (!bus.oLoHit) begin
                    if (cum >= pctl_lo) begin
                        bus.oThreshLo <= bin_idx;
                        bus.oLoHit    <= 1'b1;
                    end else if (bin_idx == LAST_BIN) begin
                        bus.oThreshLo <= LAST_BIN;
                    end
                end
                if (!bus.oHiHit) begin
                    if (cum >= pctl_hi) begin
                        bus.oThreshHi <= bin_idx;
                        bus.oHiHit    <= 1'b1;
                    end else if (bin_idx == LAST_BIN) begin
                        bus.oThreshHi <= LAST_BIN;
                    end
                end

                // Strict compare keeps the lowest bin on ties.
                if (bus.iQInHist > bus.oMaxValue) begin
                    bus.oMaxValue <= bus.iQInHist;
                    bus.oMaxBin   <= bin_idx;
                end
            end

            if (state == FLUSH && last_wr_seen)
                bus.oTotal <= acc;
        end
    end
endmodule

// File: tb/tb_cumulative_histogram_pctl.sv
// ----------------------------------------------------------------------------
// tb_cumulative_histogram_pctl
//   Two engines (read latency 1 and 3) share one histogram and one set of
//   control inputs. Each sees a pipelined RAM model of its own latency.
//   Expected results come from a plain-arithmetic model of the histogram.
// ----------------------------------------------------------------------------
module tb_cumulative_histogram_pctl;
    localparam int     BB   = 8;
    localparam int     CW   = 20;
    localparam int     NB   = 1 << BB;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic          iClk    = 1'b0;
    logic          iRst    = 1'b1;
    logic          start   = 1'b0;
    logic          ack     = 1'b0;
    logic [CW-1:0] pctl_lo = '0;
    logic [CW-1:0] pctl_hi = '0;

    always #5 iClk = ~iClk;

    cumulative_histogram_pctl_if #(.BIN_BITS(BB), .COUNT_WIDTH(CW)) bus1 ();
    cumulative_histogram_pctl_if #(.BIN_BITS(BB), .COUNT_WIDTH(CW)) bus3 ();

    assign bus1.iStart  = start;
    assign bus1.iAck    = ack;
    assign bus1.iPctlLo = pctl_lo;
    assign bus1.iPctlHi = pctl_hi;
    assign bus3.iStart  = start;
    assign bus3.iAck    = ack;
    assign bus3.iPctlLo = pctl_lo;
    assign bus3.iPctlHi = pctl_hi;

    cumulative_histogram_pctl #(.BIN_BITS(BB), .COUNT_WIDTH(CW), .READ_LATENCY(1)) dut1 (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus1.slave)
    );
    cumulative_histogram_pctl #(.BIN_BITS(BB), .COUNT_WIDTH(CW), .READ_LATENCY(3)) dut3 (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus3.slave)
    );

    // Histogram RAM with 1- and 3-cycle read pipelines
    logic [CW-1:0] hist [NB];
    logic [CW-1:0] rd1;
    logic [CW-1:0] rd3 [3];

    always @(posedge iClk) begin
        rd1    <= hist[bus1.oAddrInHist];
        rd3[0] <= hist[bus3.oAddrInHist];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign bus1.iQInHist = rd1;
    assign bus3.iQInHist = rd3[2];

    // Edges since the edge that sampled start
    int cyc = 0;
    always @(posedge iClk) cyc <= start ? 0 : cyc + 1;

    // Cumulative RAM capture and timing monitors, one per engine
    longint cum1 [NB];
    longint cum3 [NB];
    int     wcnt1, werr1, busy1, done_at1;
    int     wcnt3, werr3, busy3, done_at3;
    bit     dseen1, dseen3;

    always @(negedge iClk) begin
        if (start) begin
            wcnt1 <= 0; werr1 <= 0; busy1 <= 0; dseen1 <= 1'b0; done_at1 <= -1;
        end else begin
            if (bus1.oWE) begin
                if (int'(bus1.oAddrOutCumH) != wcnt1) werr1 <= werr1 + 1;
                cum1[bus1.oAddrOutCumH] <= longint'(bus1.oDataOutCumH);
                wcnt1 <= wcnt1 + 1;
            end
            if (bus1.oBusy) busy1 <= busy1 + 1;
            if (bus1.oDone && !dseen1) begin dseen1 <= 1'b1; done_at1 <= cyc; end
        end
    end

    always @(negedge iClk) begin
        if (start) begin
            wcnt3 <= 0; werr3 <= 0; busy3 <= 0; dseen3 <= 1'b0; done_at3 <= -1;
        end else begin
            if (bus3.oWE) begin
                if (int'(bus3.oAddrOutCumH) != wcnt3) werr3 <= werr3 + 1;
                cum3[bus3.oAddrOutCumH] <= longint'(bus3.oDataOutCumH);
                wcnt3 <= wcnt3 + 1;
            end
            if (bus3.oBusy) busy3 <= busy3 + 1;
            if (bus3.oDone && !dseen3) begin dseen3 <= 1'b1; done_at3 <= cyc; end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: running sum clamped at the count ceiling, first
    // crossings of each target, first strict maximum.
    longint e_cum [NB];
    longint e_total, e_max;
    int     e_maxb, e_thlo, e_thhi;
    bit     e_lohit, e_hihit, e_ovf;

    task automatic model(input longint lo, input longint hi);
        longint run = 0;
        e_max = 0; e_maxb = 0; e_ovf = 1'b0;
        e_lohit = 1'b0; e_hihit = 1'b0; e_thlo = NB - 1; e_thhi = NB - 1;
        for (int k = 0; k < NB; k++) begin
            run += longint'(hist[k]);
            if (run > CMAX) begin run = CMAX; e_ovf = 1'b1; end
            e_cum[k] = run;
            if (!e_lohit && run >= lo) begin e_lohit = 1'b1; e_thlo = k; end
            if (!e_hihit && run >= hi) begin e_hihit = 1'b1; e_thhi = k; end
            if (longint'(hist[k]) > e_max) begin e_max = longint'(hist[k]); e_maxb = k; end
        end
        e_total = run;
    endtask

    function automatic longint raw_total();
        longint s = 0;
        for (int k = 0; k < NB; k++) s += longint'(hist[k]);
        return s;
    endfunction

    task automatic fill_const(input int v);
        for (int k = 0; k < NB; k++) hist[k] = CW'(v);
    endtask

    task automatic fill_rand(input int unsigned maxv);
        for (int k = 0; k < NB; k++) hist[k] = CW'($urandom_range(0, maxv));
    endtask

    task automatic check_zero(input string p,
                              input logic [63:0] addr_in, we, addr_out, data_out,
                              input logic [63:0] thlo, thhi, lohit, hihit,
                              input logic [63:0] maxv, maxb, total, ovf, busy, done);
        check({p, "_addr_in"},  addr_in,  0);
        check({p, "_we"},       we,       0);
        check({p, "_addr_out"}, addr_out, 0);
        check({p, "_data_out"}, data_out, 0);
        check({p, "_thresh_lo"}, thlo,    0);
        check({p, "_thresh_hi"}, thhi,    0);
        check({p, "_lo_hit"},   lohit,    0);
        check({p, "_hi_hit"},   hihit,    0);
        check({p, "_max_value"}, maxv,    0);
        check({p, "_max_bin"},  maxb,     0);
        check({p, "_total"},    total,    0);
        check({p, "_overflow"}, ovf,      0);
        check({p, "_busy"},     busy,     0);
        check({p, "_done"},     done,     0);
    endtask

    task automatic zero_both(input string tag);
        check_zero({tag, "/L1"}, bus1.oAddrInHist, bus1.oWE, bus1.oAddrOutCumH, bus1.oDataOutCumH,
                   bus1.oThreshLo, bus1.oThreshHi, bus1.oLoHit, bus1.oHiHit, bus1.oMaxValue,
                   bus1.oMaxBin, bus1.oTotal, bus1.oOverflow, bus1.oBusy, bus1.oDone);
        check_zero({tag, "/L3"}, bus3.oAddrInHist, bus3.oWE, bus3.oAddrOutCumH, bus3.oDataOutCumH,
                   bus3.oThreshLo, bus3.oThreshHi, bus3.oLoHit, bus3.oHiHit, bus3.oMaxValue,
                   bus3.oMaxBin, bus3.oTotal, bus3.oOverflow, bus3.oBusy, bus3.oDone);
    endtask

    task automatic check_inst(input string p, input int lat,
                              input logic [63:0] thlo, thhi, lohit, hihit, maxv, maxb,
                              input logic [63:0] total, ovf, busy, done, we,
                              input int wcnt, werr, done_at, busy_cnt,
                              input longint c [NB]);
        int bad = 0;
        check({p, "_thresh_lo"}, thlo,  e_thlo);
        check({p, "_thresh_hi"}, thhi,  e_thhi);
        check({p, "_lo_hit"},    lohit, e_lohit);
        check({p, "_hi_hit"},    hihit, e_hihit);
        check({p, "_max_value"}, maxv,  e_max);
        check({p, "_max_bin"},   maxb,  e_maxb);
        check({p, "_total"},     total, e_total);
        check({p, "_overflow"},  ovf,   e_ovf);
        check({p, "_done"},      done,  1);
        check({p, "_busy"},      busy,  0);
        check({p, "_we_in_done"}, we,   0);
        check({p, "_write_count"}, wcnt, NB);
        check({p, "_write_order_errs"}, werr, 0);
        check({p, "_done_latency"}, done_at, NB + lat + 1);
        check({p, "_busy_cycles"}, busy_cnt, NB + lat + 1);
        for (int k = 0; k < NB; k++) if (c[k] != e_cum[k]) bad++;
        check({p, "_cum_ram_bad_bins"}, bad, 0);
    endtask

    task automatic check_results(input string tag);
        check_inst({tag, "/L1"}, 1, bus1.oThreshLo, bus1.oThreshHi, bus1.oLoHit, bus1.oHiHit,
                   bus1.oMaxValue, bus1.oMaxBin, bus1.oTotal, bus1.oOverflow, bus1.oBusy,
                   bus1.oDone, bus1.oWE, wcnt1, werr1, done_at1, busy1, cum1);
        check_inst({tag, "/L3"}, 3, bus3.oThreshLo, bus3.oThreshHi, bus3.oLoHit, bus3.oHiHit,
                   bus3.oMaxValue, bus3.oMaxBin, bus3.oTotal, bus3.oOverflow, bus3.oBusy,
                   bus3.oDone, bus3.oWE, wcnt3, werr3, done_at3, busy3, cum3);
    endtask

    task automatic set_targets(input longint lo, input longint hi);
        longint l = (lo > CMAX) ? CMAX : lo;
        longint h = (hi > CMAX) ? CMAX : hi;
        pctl_lo = l[CW-1:0];
        pctl_hi = h[CW-1:0];
        model(l, h);
    endtask

    task automatic start_pulse(input logic with_ack);
        @(posedge iClk); #1;
        start = 1'b1;
        ack   = with_ack;
        @(posedge iClk); #1;
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(bus1.oDone && bus3.oDone) && n < 3000) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 3000) check({tag, "_done_timeout"}, 1, 0);
        @(posedge iClk); #1;
    endtask

    task automatic run_scan(input string tag, input longint lo, input longint hi, input bit ack_mid);
        set_targets(lo, hi);
        start_pulse(1'b0);
        if (ack_mid) begin
            repeat (10) @(posedge iClk);
            #1 ack = 1'b1;
            repeat (5) @(posedge iClk);
            #1 ack = 1'b0;
        end
        wait_done(tag);
        check_results(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint t, lo, hi;
        fill_const(0);
        #12;
        zero_both("reset");
        @(posedge iClk); #1 iRst = 1'b0;

        fill_const(1500);
        run_scan("uniform", 96000, 288000, 1'b0);
        check("uniform_thresh_lo_const", bus1.oThreshLo, 63);
        check("uniform_thresh_hi_const", bus1.oThreshHi, 191);
        check("uniform_total_const", bus3.oTotal, 384000);

        fill_const(0);
        hist[200] = CW'(384000);
        run_scan("spike", 1, 384000, 1'b0);

        fill_rand(7);
        run_scan("unreached_hi", longint'($urandom_range(1, 400)), 5000, 1'b0);

        fill_const(5000);
        run_scan("overflow", 1000000, CMAX, 1'b0);

        for (int it = 0; it < 6; it++) begin
            int sel = it % 3;
            fill_rand(sel == 0 ? 15 : (sel == 1 ? 4095 : 65535));
            t  = raw_total();
            if (t > CMAX) t = CMAX;
            lo = (it == 0) ? 0 : longint'($urandom_range(0, int'(t)));
            hi = longint'($urandom_range(0, int'(t + t / 8)));
            run_scan($sformatf("random%0d", it), lo, hi, it[0]);
        end

        // Acknowledge in DONE: back to idle, results kept
        #0 ack = 1'b1;
        @(posedge iClk); #1 ack = 1'b0;
        check("ack/L1_done", bus1.oDone, 0);
        check("ack/L3_done", bus3.oDone, 0);
        check("ack/L1_busy", bus1.oBusy, 0);
        repeat (3) @(posedge iClk); #1;
        check("ack/L1_done_later", bus1.oDone, 0);
        check("ack/L1_we", bus1.oWE, 0);
        check("ack/L1_thresh_hi_kept", bus1.oThreshHi, e_thhi);
        check("ack/L3_total_kept", bus3.oTotal, e_total);
        check("ack/L1_max_bin_kept", bus1.oMaxBin, e_maxb);

        // Restart in the middle of a scan with a different histogram
        fill_rand(4095);
        set_targets(raw_total() / 3, raw_total() / 2);
        start_pulse(1'b0);
        repeat (100) @(posedge iClk);
        #1 fill_rand(2047);
        set_targets(raw_total() / 4, raw_total() - 1);
        start_pulse(1'b0);
        wait_done("restart");
        check_results("restart");

        // Start and ack together in DONE: start wins
        fill_rand(1023);
        set_targets(raw_total() / 10, raw_total() * 9 / 10);
        start_pulse(1'b1);
        check("start_ack/L1_busy", bus1.oBusy, 1);
        check("start_ack/L3_done", bus3.oDone, 0);
        wait_done("start_ack");
        check_results("start_ack");

        // Async reset in the middle of a scan
        fill_rand(4095);
        hist[0] = CW'(77);
        set_targets(100, 200);
        start_pulse(1'b0);
        repeat (40) @(posedge iClk);
        #3 iRst = 1'b1;
        #1 zero_both("async_rst");
        @(posedge iClk); #1 iRst = 1'b0;

        fill_const(1500);
        run_scan("after_rst", 96000, 288000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
